data_mem_arbiter: RTL and testbench

//  Shares the single-port data memory between the CPU load/store stage (master 0) and the

---
 rtl/data_mem_pkg.sv | 24 ++
 rtl/data_mem_starve_ctr.sv | 39 +++
 rtl/data_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
// Shared types and constants for the data memory arbiter.
//   mst_e        : master identifier (CPU load/store stage, DMA port)
//   rd_state_e   : read-return tracker states
//   WORD_ALIGN_MASK : clears byte offset bits of a byte address
// ---------------------------------------------------------------------------
package data_mem_pkg;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_DMA = 1'b1
  } mst_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CPU  = 2'd1,
    RD_DMA  = 2'd2,
    RD_NULL = 2'd3
  } rd_state_e;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/data_mem_starve_ctr.sv
// ---------------------------------------------------------------------------
// data_mem_starve_ctr
// Counts consecutive cycles a DMA request waits without a grant, saturating
// at STARVE_MAX. Cleared when the request is granted or withdrawn.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   i_waiting  : DMA request asserted this cycle
//   i_granted  : DMA granted this cycle
//   o_at_max   : counter has reached STARVE_MAX (DMA must win next contention)
// ---------------------------------------------------------------------------
module data_mem_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_waiting,
  input  logic i_granted,
  output logic o_at_max
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_waiting || i_granted) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_max = (r_cnt == CNT_MAX);

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single-port data memory between the CPU load/store stage and the
// DMA port. One access per cycle, CPU priority with bounded DMA starvation,
// read data routed back to the owner on the following cycle.
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/we/addr/wdata -> cpu_gnt, cpu_rvalid, cpu_rdata   (master 0)
//   dma_req/we/addr/wdata -> dma_gnt, dma_rvalid, dma_rdata   (master 1)
//   mem_addr/mem_wdata/mem_read/mem_write -> DataMem, mem_rdata <- DataMem
// Optional: define DATA_MEM_TRACE_EN for a simulation-only access trace.
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned MEM_BYTES  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  logic        w_at_max;
  logic        w_cpu_gnt;
  logic        w_dma_gnt;
  logic        w_gnt_any;
  mst_e        w_sel;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_mapped;
  rd_state_e   w_rd_next;

  rd_state_e   r_state;
  logic        r_cpu_rvalid;
  logic        r_dma_rvalid;

  data_mem_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk       (clk),
    .reset     (reset),
    .i_waiting (dma_req),
    .i_granted (w_dma_gnt),
    .o_at_max  (w_at_max)
  );

  // Grants are gated by reset so nothing is issued while the block is held in reset.
  assign w_dma_gnt = reset & dma_req & (~cpu_req | w_at_max);
  assign w_cpu_gnt = reset & cpu_req & ~w_dma_gnt;
  assign w_gnt_any = w_cpu_gnt | w_dma_gnt;
  assign w_sel     = w_dma_gnt ? MST_DMA : MST_CPU;

  assign w_we     = (w_sel == MST_DMA) ? dma_we    : cpu_we;
  assign w_addr   = (w_sel == MST_DMA) ? dma_addr  : cpu_addr;
  assign w_wdata  = (w_sel == MST_DMA) ? dma_wdata : cpu_wdata;
  assign w_mapped = (w_addr < 32'(MEM_BYTES));

  assign cpu_gnt   = w_cpu_gnt;
  assign dma_gnt   = w_dma_gnt;
  assign mem_addr  = w_gnt_any ? (w_addr & WORD_ALIGN_MASK) : '0;
  assign mem_wdata = w_gnt_any ? w_wdata : '0;
  // Unmapped accesses are granted but never strobe the memory.
  assign mem_read  = w_gnt_any & w_mapped & ~w_we;
  assign mem_write = w_gnt_any & w_mapped &  w_we;

  always_comb begin
    w_rd_next = RD_IDLE;
    if (w_gnt_any && !w_we) begin
      if (!w_mapped)              w_rd_next = RD_NULL;
      else if (w_sel == MST_DMA)  w_rd_next = RD_DMA;
      else                        w_rd_next = RD_CPU;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RD_IDLE;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_state      <= w_rd_next;
      r_cpu_rvalid <= (w_rd_next != RD_IDLE) && (w_sel == MST_CPU);
      r_dma_rvalid <= (w_rd_next != RD_IDLE) && (w_sel == MST_DMA);
    end
  end

  assign cpu_rvalid = r_cpu_rvalid;
  assign dma_rvalid = r_dma_rvalid;
  // RD_NULL returns zero data; only a mapped read forwards the memory output.
  assign cpu_rdata  = (r_cpu_rvalid && r_state == RD_CPU) ? mem_rdata : '0;
  assign dma_rdata  = (r_dma_rvalid && r_state == RD_DMA) ? mem_rdata : '0;

`ifdef DATA_MEM_TRACE_EN
  always @(posedge clk) begin
    if (reset) begin
      if (w_gnt_any) begin
        if (w_we)
          $display("%0t DMEM %s WRITE addr=0x%08H data=0x%08H (%0d)%s", $time,
                   (w_sel == MST_DMA) ? "DMA" : "CPU", w_addr, w_wdata,
                   $signed(w_wdata), w_mapped ? "" : " UNMAPPED");
        else
          $display("%0t DMEM %s READ  addr=0x%08H%s", $time,
                   (w_sel == MST_DMA) ? "DMA" : "CPU", w_addr,
                   w_mapped ? "" : " UNMAPPED");
      end
      if (r_cpu_rvalid)
        $display("%0t DMEM CPU RDATA 0x%08H (%0d)", $time, cpu_rdata, $signed(cpu_rdata));
      if (r_dma_rvalid)
        $display("%0t DMEM DMA RDATA 0x%08H (%0d)", $time, dma_rdata, $signed(dma_rdata));
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int MEM_BYTES  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [31:0] cpu_rdata, dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clk = ~clk;

  data_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Environment DataMem: synchronous read, garbage on the read port when idle.
  logic [31:0] env_mem [256];
  always @(posedge clk) begin
    if (mem_write) env_mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem_read ? env_mem[mem_addr[9:2]] : $urandom;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word-addressed memory image, consecutive lost cycles of DMA,
  // and per-master queues of expected read returns.
  logic [31:0] mdl_mem [256];
  int          lost = 0;
  logic [31:0] q_cpu [$];
  logic [31:0] q_dma [$];

  task automatic do_cycle(input logic cr, input logic cwe, input logic [31:0] ca,
                          input logic [31:0] cwd, input logic dr, input logic dwe,
                          input logic [31:0] da, input logic [31:0] dwd,
                          output logic cg, output logic dg);
    logic        eg_c, eg_d, we;
    logic [31:0] a, wd, ed;
    logic        mapped;
    @(negedge clk);
    cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dr; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
    #1;
    eg_d = dr && (!cr || lost == STARVE_MAX);
    eg_c = cr && !eg_d;
    chk1("cpu_gnt", cpu_gnt, eg_c);
    chk1("dma_gnt", dma_gnt, eg_d);
    if (eg_c || eg_d) begin
      we = eg_d ? dwe : cwe;
      a  = eg_d ? da  : ca;
      wd = eg_d ? dwd : cwd;
      mapped = (a < MEM_BYTES);
      chk1("mem_read", mem_read, mapped && !we);
      chk1("mem_write", mem_write, mapped && we);
      chk32("mem_addr", mem_addr, (a / 4) * 4);
      chk32("mem_wdata", mem_wdata, wd);
      if (!we) begin
        ed = mapped ? mdl_mem[a / 4] : 32'h0;
        if (eg_d) q_dma.push_back(ed); else q_cpu.push_back(ed);
      end else if (mapped) begin
        mdl_mem[a / 4] = wd;
      end
    end else begin
      chk1("idle_mem_read", mem_read, 1'b0);
      chk1("idle_mem_write", mem_write, 1'b0);
      chk32("idle_mem_addr", mem_addr, 32'h0);
      chk32("idle_mem_wdata", mem_wdata, 32'h0);
    end
    if (dr && !eg_d) lost = (lost < STARVE_MAX) ? lost + 1 : STARVE_MAX;
    else             lost = 0;
    cg = eg_c;
    dg = eg_d;
  endtask

  task automatic idle_cycle();
    logic g0, g1;
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, g0, g1);
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_cpu_gnt"}, cpu_gnt, 1'b0);
    chk1({tag, "_dma_gnt"}, dma_gnt, 1'b0);
    chk1({tag, "_mem_read"}, mem_read, 1'b0);
    chk1({tag, "_mem_write"}, mem_write, 1'b0);
    chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk32({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk1({tag, "_cpu_rvalid"}, cpu_rvalid, 1'b0);
    chk1({tag, "_dma_rvalid"}, dma_rvalid, 1'b0);
    chk32({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk32({tag, "_dma_rdata"}, dma_rdata, 32'h0);
  endtask

  // Assert reset mid-cycle while requests stay asserted; any read granted this
  // cycle is dropped by the model.
  task automatic apply_reset();
    reset = 1'b0;
    q_cpu.delete();
    q_dma.delete();
    lost = 0;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    #2;
    check_all_zero("rst_held");
    @(negedge clk);
    cpu_req = 1'b0; dma_req = 1'b0;
    reset = 1'b1;
  endtask

  // Monitor: each read granted in cycle N must return exactly at the next edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk1("cpu_rvalid", cpu_rvalid, q_cpu.size() != 0);
      if (cpu_rvalid && q_cpu.size() != 0) chk32("cpu_rdata", cpu_rdata, q_cpu.pop_front());
      else if (!cpu_rvalid) chk32("cpu_rdata_idle", cpu_rdata, 32'h0);
      chk1("dma_rvalid", dma_rvalid, q_dma.size() != 0);
      if (dma_rvalid && q_dma.size() != 0) chk32("dma_rdata", dma_rdata, q_dma.pop_front());
      else if (!dma_rvalid) chk32("dma_rdata_idle", dma_rdata, 32'h0);
    end
  end

  logic        cg, dg;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wd, d_addr, d_wd;

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] <= 32'h0;
      mdl_mem[i] = 32'h0;
    end
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    #2;
    check_all_zero("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_cycle();

    // Reset mid-read: read granted, reset asserted before the return edge.
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, cg, dg);
    chk1("t1_gnt", cg, 1'b1);
    apply_reset();
    idle_cycle();

    // Contention: CPU wins four cycles, DMA the fifth, repeating.
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b1, 1'b0, 32'(4 * i), 32'h0, 1'b1, 1'b0, 32'(256 + 4 * i), 32'h0, cg, dg);
      chk1("t2_dma_turn", dma_gnt, (i % 5) == 4);
    end
    idle_cycle();

    // Write then back-to-back DMA read of the same word.
    do_cycle(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, cg, dg);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, cg, dg);
    chk1("t3_dma_gnt", dg, 1'b1);
    @(posedge clk);
    #2;
    chk32("t3_dma_rdata", dma_rdata, 32'hDEADBEEF);

    // Misaligned read is word-aligned toward the memory.
    do_cycle(1'b1, 1'b0, 32'h23, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, cg, dg);
    chk32("t4_mem_addr", mem_addr, 32'h20);
    chk1("t4_mem_read", mem_read, 1'b1);
    idle_cycle();
    chk1("t4_read_one_cycle", mem_read, 1'b0);

    // Unmapped write and read at MEM_BYTES.
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h400, 32'h12345678, cg, dg);
    chk1("t5_wr_gnt", dma_gnt, 1'b1);
    chk1("t5_wr_strobe", mem_write, 1'b0);
    do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, cg, dg);
    chk1("t5_rd_strobe", mem_read, 1'b0);
    idle_cycle();

    // DMA waits three cycles then withdraws; the counter restarts from zero.
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, cg, dg);
    do_cycle(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, cg, dg);
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 1'b0, 32'h48, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0, cg, dg);
      chk1("t6_cpu_wins", cpu_gnt, i != 4);
    end
    idle_cycle();

    // Randomized traffic: requests held until granted, fields may change while waiting.
    c_req = 1'b0; d_req = 1'b0;
    c_we = 1'b0; d_we = 1'b0; c_addr = '0; d_addr = '0; c_wd = '0; d_wd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!c_req) c_req = ($urandom_range(0, 3) != 0);
      if (!d_req) d_req = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0 || !cpu_req) begin
        c_we = ($urandom_range(0, 1) == 1);
        c_addr = $urandom_range(0, 1151);
        c_wd = $urandom;
      end
      if ($urandom_range(0, 3) == 0 || !dma_req) begin
        d_we = ($urandom_range(0, 1) == 1);
        d_addr = $urandom_range(0, 1151);
        d_wd = $urandom;
      end
      do_cycle(c_req, c_we, c_addr, c_wd, d_req, d_we, d_addr, d_wd, cg, dg);
      if (cg) c_req = 1'b0;
      if (dg) d_req = 1'b0;
    end
    idle_cycle();
    idle_cycle();
    chk32("cpu_queue_drained", 32'(q_cpu.size()), 32'h0);
    chk32("dma_queue_drained", 32'(q_dma.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
